sfifo_pack: RTL

- Single-clock, parametrised successor to the 8-in/32-out width-converting FIFO.
- Packs RATIO narrow write words into one wide entry, stored in a 2**AW-deep buffer.
- Adds selectable packing order, early push of partial words via wlast, fill level, almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
- Sits between a byte-stream producer and a word-wide consumer in the same clock domain.

---
 rtl/sfifo_pack_pkg.sv | 31 +++
 rtl/sfifo_pack_if.sv | 39 +++
 rtl/sfifo_pack_ram.sv | 34 +++
 rtl/sfifo_pack.sv | 136 +++++++++++++
 4 files changed

// File: rtl/sfifo_pack_pkg.sv
// Shared sizing helpers and slot mapping for the packing FIFO.
package sfifo_pack_pkg;

   // Ceiling log2, usable in parameter and localparam expressions.
   function automatic int unsigned clog2_f(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = 1;
      for (int i = 0; i < 32; i++) begin
         if (v < n) begin
            v = v << 1;
            r = r + 1;
         end
      end
      return r;
   endfunction

   // Number of entries for a given address width.
   function automatic int unsigned depth_f(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

   // Slot in the pack register receiving the pcnt-th word of an entry.
   function automatic int unsigned slot_idx(input int unsigned pcnt,
                                            input int unsigned ratio,
                                            input bit          msb_first);
      return msb_first ? (ratio - 1 - pcnt) : pcnt;
   endfunction

endpackage

// File: rtl/sfifo_pack_if.sv
// Producer/consumer bundle of the packing FIFO.
interface sfifo_pack_if
   import sfifo_pack_pkg::*;
#(
   parameter int unsigned DW    = 8,
   parameter int unsigned RATIO = 4,
   parameter int unsigned AW    = 4
);
   localparam int unsigned CW = clog2_f(RATIO) + 1;

   logic                flush;
   logic                wren;
   logic [DW-1:0]       wdata;
   logic                wlast;
   logic                wfull;
   logic                rden;
   logic [DW*RATIO-1:0] rdata;
   logic [CW-1:0]       rnwords;
   logic                rdready;
   logic                rempty;
   logic [AW:0]         level;
   logic                almost_full;
   logic                almost_empty;
   logic                ovf;
   logic                udf;

   modport master (
      output flush, wren, wdata, wlast, rden,
      input  wfull, rdata, rnwords, rdready, rempty, level,
             almost_full, almost_empty, ovf, udf
   );

   modport slave (
      input  flush, wren, wdata, wlast, rden,
      output wfull, rdata, rnwords, rdready, rempty, level,
             almost_full, almost_empty, ovf, udf
   );

endinterface

// File: rtl/sfifo_pack_ram.sv
// Simple dual-port entry store with a registered, clearable read port.
module sfifo_pack_ram
   import sfifo_pack_pkg::*;
#(
   parameter int unsigned AW = 4,
   parameter int unsigned EW = 35
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          clr,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [EW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [EW-1:0] rdata
);
   localparam int unsigned DEPTH = depth_f(AW);

   logic [EW-1:0] mem [DEPTH];

   // Write port: storage array carries no reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read port: output register holds until the next accepted read.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)    rdata <= '0;
      else if (clr) rdata <= '0;
      else if (re)  rdata <= mem[raddr];
   end

endmodule

// File: rtl/sfifo_pack.sv
// Narrow-to-wide packing FIFO with partial push, level and sticky error flags.
module sfifo_pack
   import sfifo_pack_pkg::*;
#(
   parameter int unsigned DW        = 8,
   parameter int unsigned RATIO     = 4,
   parameter int unsigned AW        = 4,
   parameter int unsigned MSB_FIRST = 0,
   parameter int unsigned AF_LVL    = 2**AW - 2,
   parameter int unsigned AE_LVL    = 1
) (
   input logic         clk,
   input logic         rstn,
   sfifo_pack_if.slave bus
);
   localparam int unsigned DEPTH = depth_f(AW);
   localparam int unsigned PW    = clog2_f(RATIO);
   localparam int unsigned CW    = PW + 1;
   localparam int unsigned WW    = DW * RATIO;
   localparam int unsigned EW    = WW + CW;
   localparam int unsigned LW    = AW + 1;

   logic [LW-1:0] wptr_q, wptr_n, rptr_q, rptr_n;
   logic [LW-1:0] level_q, level_n;
   logic [PW-1:0] pcnt_q, pcnt_n;
   logic [WW-1:0] pack_q, pack_n, pack_word;
   logic          rempty_q, afull_q, aempty_q;
   logic          rdready_q, rdready_n;
   logic          ovf_q, ovf_n, udf_q, udf_n;
   logic          wr_acc, rd_acc, push, wfull_c;
   logic [EW-1:0] ram_wdata, ram_rdata;

   // Refuse a write only when it would push into a full buffer.
   always_comb begin
      wfull_c = (level_q == LW'(DEPTH)) & ((pcnt_q == PW'(RATIO - 1)) | bus.wlast);
   end

   // Next-state for pointers, pack register and flags; flush overrides all.
   always_comb begin
      wr_acc    = bus.wren & ~wfull_c;
      rd_acc    = bus.rden & ~rempty_q;
      push      = wr_acc & ((pcnt_q == PW'(RATIO - 1)) | bus.wlast);
      pack_word = pack_q;
      for (int unsigned s = 0; s < RATIO; s++) begin
         if (s == slot_idx(32'(pcnt_q), RATIO, MSB_FIRST != 0))
            pack_word[s*DW +: DW] = bus.wdata;
      end
      pack_n    = pack_q;
      pcnt_n    = pcnt_q;
      wptr_n    = wptr_q + LW'(push);
      rptr_n    = rptr_q + LW'(rd_acc);
      ovf_n     = ovf_q | (bus.wren & wfull_c);
      udf_n     = udf_q | (bus.rden & rempty_q);
      rdready_n = rd_acc;
      if (wr_acc) begin
         if (push) begin
            pack_n = '0;
            pcnt_n = '0;
         end else begin
            pack_n = pack_word;
            pcnt_n = pcnt_q + PW'(1);
         end
      end
      if (bus.flush) begin
         pack_n    = '0;
         pcnt_n    = '0;
         wptr_n    = '0;
         rptr_n    = '0;
         ovf_n     = 1'b0;
         udf_n     = 1'b0;
         rdready_n = 1'b0;
      end
      level_n = wptr_n - rptr_n;
   end

   // State and registered status outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         pcnt_q    <= '0;
         pack_q    <= '0;
         level_q   <= '0;
         rempty_q  <= 1'b1;
         afull_q   <= 1'b0;
         aempty_q  <= 1'b1;
         rdready_q <= 1'b0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
      end else begin
         wptr_q    <= wptr_n;
         rptr_q    <= rptr_n;
         pcnt_q    <= pcnt_n;
         pack_q    <= pack_n;
         level_q   <= level_n;
         rempty_q  <= (level_n == '0);
         afull_q   <= (level_n >= LW'(AF_LVL));
         aempty_q  <= (level_n <= LW'(AE_LVL));
         rdready_q <= rdready_n;
         ovf_q     <= ovf_n;
         udf_q     <= udf_n;
      end
   end

   // Stored entry carries its valid word count above the data.
   always_comb begin
      ram_wdata = {CW'(pcnt_q) + CW'(1), pack_word};
   end

   sfifo_pack_ram #(
      .AW (AW),
      .EW (EW)
   ) u_ram (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (bus.flush),
      .we    (push & ~bus.flush),
      .waddr (wptr_q[AW-1:0]),
      .wdata (ram_wdata),
      .re    (rd_acc & ~bus.flush),
      .raddr (rptr_q[AW-1:0]),
      .rdata (ram_rdata)
   );

   assign bus.wfull        = wfull_c;
   assign bus.rdata        = ram_rdata[WW-1:0];
   assign bus.rnwords      = ram_rdata[EW-1:WW];
   assign bus.rdready      = rdready_q;
   assign bus.rempty       = rempty_q;
   assign bus.level        = level_q;
   assign bus.almost_full  = afull_q;
   assign bus.almost_empty = aempty_q;
   assign bus.ovf          = ovf_q;
   assign bus.udf          = udf_q;

endmodule
